// File: rtl/byte_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : byte_unit_pipe                                                   |
// | Purpose : Pipelined byte-class execution unit (cntb, avgb, absdb, sumb)    |
// |           over a W_BYTES-wide vector, with valid/ready handshake, global   |
// |           stall, flush and a configurable number of register stages.       |
// | Ports   : clk, reset (async, active-low)                                   |
// |           in_valid/in_ready, data_ra, data_rb, opcode, addr_rt, flush      |
// |           out_valid/out_ready, out_data, out_rt, out_wr, out_illegal       |
// | Config  : BYTE_UNIT_ILLEGAL_TRAP_EN - when defined, an unrecognised opcode |
// |           raises out_illegal with its (zero, non-writing) result.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module byte_unit_pipe #(
  parameter int W_BYTES = 16,  // multiple of 4
  parameter int STAGES  = 2,   // >= 1
  parameter int RT_W    = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W_BYTES*8-1:0] data_ra,
  input  logic [W_BYTES*8-1:0] data_rb,
  input  logic [10:0]          opcode,
  input  logic [RT_W-1:0]      addr_rt,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W_BYTES*8-1:0] out_data,
  output logic [RT_W-1:0]      out_rt,
  output logic                 out_wr,
  output logic                 out_illegal
);

  localparam int DW      = W_BYTES * 8;
  localparam int N_WORDS = W_BYTES / 4;

  localparam logic [10:0] OP_CNTB  = 11'b01010110100;
  localparam logic [10:0] OP_AVGB  = 11'b00011010011;
  localparam logic [10:0] OP_ABSDB = 11'b00001010011;
  localparam logic [10:0] OP_SUMB  = 11'b01001010011;

  // ---------------------------------------------------------------------------
  // Per-byte / per-word operators
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] popcnt8(input logic [7:0] x);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) n = n + {3'b000, x[k]};
    return {4'b0000, n};
  endfunction

  // 9-bit intermediate keeps the carry of a + b + 1 before halving.
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  function automatic logic [7:0] absd8(input logic [7:0] a, input logic [7:0] b);
    return (b >= a) ? (b - a) : (a - b);
  endfunction

  function automatic logic [15:0] sum4(input logic [31:0] w);
    logic [9:0] s;
    s = {2'b00, w[31:24]} + {2'b00, w[23:16]} + {2'b00, w[15:8]} + {2'b00, w[7:0]};
    return {6'd0, s};
  endfunction

  // ---------------------------------------------------------------------------
  // Entry-stage compute. Byte 0 is the most significant byte of the vector,
  // so byte i lives at [DW-1-8i -: 8] and word j at [DW-1-32j -: 32].
  // ---------------------------------------------------------------------------
  logic [DW-1:0] result;
  logic          known;

  always_comb begin
    result = '0;
    known  = 1'b1;
    case (opcode)
      OP_CNTB:
        for (int i = 0; i < W_BYTES; i++)
          result[DW-1-8*i -: 8] = popcnt8(data_ra[DW-1-8*i -: 8]);
      OP_AVGB:
        for (int i = 0; i < W_BYTES; i++)
          result[DW-1-8*i -: 8] = avg8(data_ra[DW-1-8*i -: 8], data_rb[DW-1-8*i -: 8]);
      OP_ABSDB:
        for (int i = 0; i < W_BYTES; i++)
          result[DW-1-8*i -: 8] = absd8(data_ra[DW-1-8*i -: 8], data_rb[DW-1-8*i -: 8]);
      OP_SUMB:
        // Upper halfword carries the RB sum, lower halfword the RA sum.
        for (int j = 0; j < N_WORDS; j++)
          result[DW-1-32*j -: 32] = {sum4(data_rb[DW-1-32*j -: 32]),
                                     sum4(data_ra[DW-1-32*j -: 32])};
      default: known = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline. A single global advance enable: a stalled output freezes every
  // stage (bubbles are not squeezed out).
  // ---------------------------------------------------------------------------
  logic              advance;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] wr_q;
  logic [DW-1:0]     data_q [STAGES];
  logic [RT_W-1:0]   rt_q   [STAGES];

  assign out_valid = vld_q[STAGES-1];
  assign advance   = !(out_valid && !out_ready);
  assign in_ready  = advance;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      wr_q  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        rt_q[s]   <= '0;
      end
    end else begin
      // Flush overrides both a new accept and a stall; only the valid bits
      // need clearing since payload is ignored without valid.
      if (flush) begin
        vld_q <= '0;
      end else if (advance) begin
        vld_q[0] <= in_valid;
        for (int s = 1; s < STAGES; s++) vld_q[s] <= vld_q[s-1];
      end
      if (advance) begin
        wr_q[0]   <= known;
        data_q[0] <= result;
        rt_q[0]   <= addr_rt;
        for (int s = 1; s < STAGES; s++) begin
          wr_q[s]   <= wr_q[s-1];
          data_q[s] <= data_q[s-1];
          rt_q[s]   <= rt_q[s-1];
        end
      end
    end
  end

  assign out_data = data_q[STAGES-1];
  assign out_rt   = rt_q[STAGES-1];
  assign out_wr   = out_valid & wr_q[STAGES-1];

`ifdef BYTE_UNIT_ILLEGAL_TRAP_EN
  logic [STAGES-1:0] ill_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ill_q <= '0;
    end else if (advance) begin
      ill_q[0] <= !known;
      for (int s = 1; s < STAGES; s++) ill_q[s] <= ill_q[s-1];
    end
  end

  assign out_illegal = out_valid & ill_q[STAGES-1];
`else
  assign out_illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_byte_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_byte_unit_pipe                                                |
// | Purpose : Scoreboard bench for byte_unit_pipe: directed test-plan cases    |
// |           plus randomized traffic against a behavioural byte model.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_byte_unit_pipe;

  localparam int W_BYTES = 16;
  localparam int STAGES  = 2;
  localparam int RT_W    = 7;
  localparam int DW      = W_BYTES * 8;

  localparam logic [10:0] OP_CNTB  = 11'b01010110100;
  localparam logic [10:0] OP_AVGB  = 11'b00011010011;
  localparam logic [10:0] OP_ABSDB = 11'b00001010011;
  localparam logic [10:0] OP_SUMB  = 11'b01001010011;

`ifdef BYTE_UNIT_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, flush;
  logic            out_valid, out_ready, out_wr, out_illegal;
  logic [DW-1:0]   data_ra, data_rb, out_data;
  logic [10:0]     opcode;
  logic [RT_W-1:0] addr_rt, out_rt;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [RT_W-1:0] rt;
    logic            wr;
    logic            ill;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   retired = 0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  byte_unit_pipe #(.W_BYTES(W_BYTES), .STAGES(STAGES), .RT_W(RT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_ra(data_ra), .data_rb(data_rb), .opcode(opcode), .addr_rt(addr_rt),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rt(out_rt), .out_wr(out_wr), .out_illegal(out_illegal)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Behavioural model: byte i is the i-th most significant byte.
  function automatic exp_t model(input logic [10:0] op, input logic [DW-1:0] ra,
                                 input logic [DW-1:0] rb, input logic [RT_W-1:0] rt);
    exp_t e;
    int   a, b, r, sa, sr;
    e.data = '0;
    e.rt   = rt;
    e.wr   = (op == OP_CNTB) || (op == OP_AVGB) || (op == OP_ABSDB) || (op == OP_SUMB);
    e.ill  = !e.wr && TRAP;
    for (int i = 0; i < W_BYTES; i++) begin
      a = int'(ra[DW-1-8*i -: 8]);
      b = int'(rb[DW-1-8*i -: 8]);
      r = 0;
      if (op == OP_CNTB) begin
        for (int k = 0; k < 8; k++) r += (a >> k) & 1;
      end else if (op == OP_AVGB) begin
        r = (a + b + 1) / 2;
      end else if (op == OP_ABSDB) begin
        r = (a > b) ? a - b : b - a;
      end
      e.data = e.data | (DW'(r) << (DW - 8 - 8*i));
    end
    if (op == OP_SUMB) begin
      for (int j = 0; j < W_BYTES/4; j++) begin
        sa = 0;
        sr = 0;
        for (int k = 0; k < 4; k++) begin
          sa += int'(ra[DW-1-8*(4*j+k) -: 8]);
          sr += int'(rb[DW-1-8*(4*j+k) -: 8]);
        end
        e.data = e.data | (DW'(sr * 65536 + sa) << (DW - 32 - 32*j));
      end
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < DW/32; k++) v = {v[DW-33:0], 32'($urandom())};
    return v;
  endfunction

  // Monitor: every cycle, compare the presented output with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      chk1("in_ready", in_ready, !(out_valid === 1'b1 && out_ready === 1'b0));
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output rt=%0d data=%h required=none", out_rt, out_data);
        end else begin
          chk("out_data", out_data, sb[0].data);
          chk("out_rt", DW'(out_rt), DW'(sb[0].rt));
          chk1("out_wr", out_wr, sb[0].wr);
          chk1("out_illegal", out_illegal, sb[0].ill);
          if (out_ready === 1'b1) begin
            void'(sb.pop_front());
            retired++;
          end
        end
      end else begin
        chk1("idle_out_wr", out_wr, 1'b0);
        chk1("idle_out_illegal", out_illegal, 1'b0);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [10:0] op, input logic [DW-1:0] ra,
                      input logic [DW-1:0] rb, input logic [RT_W-1:0] rt);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    in_valid = 1'b1;
    opcode   = op;
    data_ra  = ra;
    data_rb  = rb;
    addr_rt  = rt;
    while (!done && n < 60) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        sb.push_back(model(op, ra, rb, rt));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout cycles=%0d required=accept", n);
    end
    in_valid = 1'b0;
  endtask

  // Send with the pipe empty and out_ready high; return in the first cycle
  // the result is visible.
  task automatic run_one(input logic [10:0] op, input logic [DW-1:0] ra,
                         input logic [DW-1:0] rb, input logic [RT_W-1:0] rt);
    out_ready = 1'b1;
    send(op, ra, rb, rt);
    for (int k = 1; k < STAGES; k++) begin
      chk1("latency_early_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    chk1("latency_valid", out_valid, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_left", DW'(sb.size()), DW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    logic [DW-1:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    data_ra = '0; data_rb = '0; opcode = '0; addr_rt = '0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_rt", DW'(out_rt), DW'(0));
    chk1("rst_out_wr", out_wr, 1'b0);
    chk1("rst_out_illegal", out_illegal, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // cntb: 0x37 -> 5, 0xFF -> 8, 0x00 -> 0
    run_one(OP_CNTB, DW'(24'h37FF00) << (DW - 24), '0, 7'd0);
    chk("cntb_bytes", DW'(out_data[DW-1 -: 24]), DW'(24'h050800));
    chk1("cntb_wr", out_wr, 1'b1);
    chk("cntb_rt", DW'(out_rt), DW'(0));

    // avgb: (FF+01+1)>>1 = 80, (00+01+1)>>1 = 01
    run_one(OP_AVGB, DW'(16'hFF00) << (DW - 16), DW'(16'h0101) << (DW - 16), 7'd1);
    chk("avgb_bytes", DW'(out_data[DW-1 -: 16]), DW'(16'h8001));

    // absdb: |05-10| = 0B
    run_one(OP_ABSDB, DW'(8'h10) << (DW - 8), DW'(8'h05) << (DW - 8), 7'd2);
    chk("absdb_byte", DW'(out_data[DW-1 -: 8]), DW'(8'h0B));

    // sumb: rb sum 0x3FC, ra sum 0x1CF
    run_one(OP_SUMB, DW'(32'h3727C5AC) << (DW - 32), DW'(32'hFFFFFFFF) << (DW - 32), 7'd3);
    chk("sumb_word0", DW'(out_data[DW-1 -: 32]), DW'(32'h03FC01CF));

    // Unrecognised opcode
    run_one(11'h000, rnd(), rnd(), 7'd5);
    chk("illegal_data", out_data, '0);
    chk1("illegal_wr", out_wr, 1'b0);
    chk1("illegal_flag", out_illegal, TRAP);
    drain();

    // Back-to-back four ops, first result stalled three cycles
    r0 = retired;
    fork
      begin
        send(OP_CNTB, rnd(), rnd(), 7'd0);
        send(OP_AVGB, rnd(), rnd(), 7'd1);
        send(OP_ABSDB, rnd(), rnd(), 7'd2);
        send(OP_SUMB, rnd(), rnd(), 7'd3);
      end
      begin
        int n;
        n = 0;
        out_ready = 1'b0;
        while (out_valid !== 1'b1 && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk1("stall_in_ready", in_ready, 1'b0);
          chk("stall_out_rt", DW'(out_rt), DW'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("b2b_retired", DW'(retired - r0), DW'(4));

    // Flush with two ops in flight and a new op offered
    r0 = retired;
    out_ready = 1'b0;
    send(OP_CNTB, rnd(), rnd(), 7'd10);
    send(OP_AVGB, rnd(), rnd(), 7'd11);
    flush = 1'b1;
    in_valid = 1'b1;
    opcode = OP_ABSDB;
    data_ra = rnd();
    addr_rt = 7'd12;
    @(posedge clk);
    #1;
    sb.delete();
    flush = 1'b0;
    in_valid = 1'b0;
    chk1("flush_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk1("flush_quiet", out_valid, 1'b0);
    end
    chk("flush_retired", DW'(retired - r0), DW'(0));

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 4))
        0: opcode = OP_CNTB;
        1: opcode = OP_AVGB;
        2: opcode = OP_ABSDB;
        3: opcode = OP_SUMB;
        default: opcode = 11'($urandom());
      endcase
      ra = rnd();
      rb = rnd();
      send(opcode, ra, rb, 7'($urandom()));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();

    // Asynchronous reset in the middle of the pipeline
    out_ready = 1'b0;
    send(OP_SUMB, rnd(), rnd(), 7'd20);
    send(OP_CNTB, rnd(), rnd(), 7'd21);
    #2 reset = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, '0);
    chk("midrst_out_rt", DW'(out_rt), DW'(0));
    chk1("midrst_out_wr", out_wr, 1'b0);
    chk1("midrst_out_illegal", out_illegal, 1'b0);
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk1("midrst_in_ready", in_ready, 1'b1);
    r0 = retired;
    idle(4);
    chk("midrst_retired", DW'(retired - r0), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
